// File: rtl/if_pc_redirect.sv
// Fetch-stage PC generator: sequential advance, branch/jump redirects, stall hold,
// and a pending-redirect buffer that covers cycles where instruction memory is not ready.
module if_pc_redirect #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_valid,
  input  logic        compareAB,
  input  logic [31:0] branch_target,
  input  logic        jump_valid,
  input  logic [31:0] jump_target,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic [15:0] br_count,
  output logic [15:0] br_taken_count
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned CNTW = 16;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
  localparam logic [CNTW-1:0] CNT_MAX    = {CNTW{1'b1}};

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pendTarget;
  logic            pendValid;
  logic            pendIsBranch;

  logic            taken;
  logic [XLEN-1:0] brTarget;
  logic [XLEN-1:0] jmpTarget;
  logic [XLEN-1:0] seqNext;
  logic            brCount;
  logic            brTakenCount;

  // Word-aligned redirect targets and the priority-resolved next PC for a ready fetch.
  assign taken     = branch_valid & compareAB;
  assign brTarget  = branch_target & ALIGN_MASK;
  assign jmpTarget = jump_target & ALIGN_MASK;
  assign pc_plus4  = pc + XLEN'(4);

  always_comb begin
    seqNext = pc_plus4;
    if (taken)           seqNext = brTarget;
    else if (jump_valid) seqNext = jmpTarget;
    else if (stall)      seqNext = pc;
  end

  // Redirects and the wrong-path squash are reported in the cycle they are seen.
  assign flush_ifid  = taken | jump_valid;
  assign flush_idex  = taken;
  assign fetch_valid = reset & imem_ready & ~stall & ~taken & ~jump_valid & ~pendValid;

  assign brCount      = branch_valid & ~stall;
  assign brTakenCount = taken & ~stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= RUN;
      pc           <= RESET_PC;
      pendTarget   <= '0;
      pendValid    <= 1'b0;
      pendIsBranch <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (imem_ready) begin
            pc <= seqNext;
          end else begin
            if (taken) begin
              pendTarget   <= brTarget;
              pendIsBranch <= 1'b1;
              pendValid    <= 1'b1;
            end else if (jump_valid) begin
              pendTarget   <= jmpTarget;
              pendIsBranch <= 1'b0;
              pendValid    <= 1'b1;
            end
            state <= WAIT;
          end
        end
        WAIT: begin
          if (!imem_ready) begin
            // An older pending branch outranks a younger jump from ID.
            if (taken) begin
              pendTarget   <= brTarget;
              pendIsBranch <= 1'b1;
              pendValid    <= 1'b1;
            end else if (jump_valid && !pendIsBranch) begin
              pendTarget   <= jmpTarget;
              pendIsBranch <= 1'b0;
              pendValid    <= 1'b1;
            end
          end else begin
            if (taken)          pc <= brTarget;
            else if (pendValid) pc <= pendTarget;
            else                pc <= seqNext;
            pendValid    <= 1'b0;
            pendIsBranch <= 1'b0;
            state        <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  // Saturating branch statistics.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      br_count       <= '0;
      br_taken_count <= '0;
    end else begin
      if (brCount && br_count != CNT_MAX)
        br_count <= br_count + CNTW'(1);
      if (brTakenCount && br_taken_count != CNT_MAX)
        br_taken_count <= br_taken_count + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_if_pc_redirect.sv
// Directed bench for if_pc_redirect with hand-computed expected values.
module tb_if_pc_redirect;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_valid;
  logic        compareAB;
  logic [31:0] branch_target;
  logic        jump_valid;
  logic [31:0] jump_target;
  logic        imem_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        flush_ifid;
  logic        flush_idex;
  logic [15:0] br_count;
  logic [15:0] br_taken_count;

  int errCount = 0;
  int chkCount = 0;

  if_pc_redirect #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .branch_valid(branch_valid),
    .compareAB(compareAB),
    .branch_target(branch_target),
    .jump_valid(jump_valid),
    .jump_target(jump_target),
    .imem_ready(imem_ready),
    .pc(pc),
    .pc_plus4(pc_plus4),
    .fetch_valid(fetch_valid),
    .flush_ifid(flush_ifid),
    .flush_idex(flush_idex),
    .br_count(br_count),
    .br_taken_count(br_taken_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chkCount++;
    if (obs !== exp) begin
      errCount++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    stall = 0; branch_valid = 0; compareAB = 0; jump_valid = 0;
    branch_target = '0; jump_target = '0; imem_ready = 1;
  endtask

  task automatic br(input logic [31:0] t, input logic tk);
    branch_valid = 1; compareAB = tk; branch_target = t;
  endtask

  task automatic jmp(input logic [31:0] t);
    jump_valid = 1; jump_target = t;
  endtask

  initial begin
    reset = 0;
    idle();
    br(32'h0000_0010, 1'b1);
    repeat (2) step();
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_pc4", pc_plus4, 32'h4);
    check("rst_fv", 32'(fetch_valid), 32'd0);
    check("rst_flush_ifid", 32'(flush_ifid), 32'd1);
    check("rst_flush_idex", 32'(flush_idex), 32'd1);
    check("rst_brc", 32'(br_count), 32'd0);
    check("rst_brtc", 32'(br_taken_count), 32'd0);

    // Sequential fetch from reset.
    @(negedge clk);
    idle();
    reset = 1;
    #1;
    check("seq_fv", 32'(fetch_valid), 32'd1);
    check("seq_pc0", pc, 32'h0);
    for (int i = 1; i < 4; i++) begin
      step();
      check("seq_pc", pc, 32'(4 * i));
    end

    // Jump to 0x20 with a misaligned target.
    jmp(32'h0000_0023);
    #1;
    check("jmp_flush_ifid", 32'(flush_ifid), 32'd1);
    check("jmp_flush_idex", 32'(flush_idex), 32'd0);
    check("jmp_fv", 32'(fetch_valid), 32'd0);
    step();
    check("jmp_pc", pc, 32'h20);

    // Taken branch overrides stall.
    idle();
    stall = 1;
    br(32'h0000_0101, 1'b1);
    #1;
    check("bst_flush_ifid", 32'(flush_ifid), 32'd1);
    check("bst_flush_idex", 32'(flush_idex), 32'd1);
    check("bst_fv", 32'(fetch_valid), 32'd0);
    step();
    check("bst_pc", pc, 32'h100);
    check("bst_brc", 32'(br_count), 32'd0);
    check("bst_brtc", 32'(br_taken_count), 32'd0);

    // Plain stall holds pc.
    idle();
    stall = 1;
    #1;
    check("stall_fv", 32'(fetch_valid), 32'd0);
    step();
    check("stall_pc", pc, 32'h100);

    idle();
    jmp(32'h40);
    step();
    check("jmp40_pc", pc, 32'h40);

    // Not-taken branch.
    idle();
    br(32'h0000_0500, 1'b0);
    #1;
    check("nt_flush_ifid", 32'(flush_ifid), 32'd0);
    check("nt_flush_idex", 32'(flush_idex), 32'd0);
    check("nt_fv", 32'(fetch_valid), 32'd1);
    step();
    check("nt_pc", pc, 32'h44);
    check("nt_brc", 32'(br_count), 32'd1);
    check("nt_brtc", 32'(br_taken_count), 32'd0);

    // Memory wait: pending jump overwritten by a later branch.
    idle();
    imem_ready = 0;
    jmp(32'h200);
    #1;
    check("mw_flush_ifid", 32'(flush_ifid), 32'd1);
    step();
    check("mw_hold1", pc, 32'h44);
    idle();
    imem_ready = 0;
    br(32'h300, 1'b1);
    #1;
    check("mw_flush_idex", 32'(flush_idex), 32'd1);
    step();
    check("mw_hold2", pc, 32'h44);
    check("mw_brc", 32'(br_count), 32'd2);
    check("mw_brtc", 32'(br_taken_count), 32'd1);
    idle();
    #1;
    check("mw_apply_fv", 32'(fetch_valid), 32'd0);
    step();
    check("mw_apply_pc", pc, 32'h300);
    check("mw_after_fv", 32'(fetch_valid), 32'd1);

    // Pending branch is not displaced by a later jump.
    idle();
    imem_ready = 0;
    br(32'h400, 1'b1);
    step();
    idle();
    imem_ready = 0;
    jmp(32'h500);
    step();
    check("pb_hold", pc, 32'h300);
    idle();
    step();
    check("pb_pc", pc, 32'h400);

    // A taken branch in the apply cycle beats a pending jump.
    idle();
    imem_ready = 0;
    jmp(32'h600);
    step();
    idle();
    br(32'h700, 1'b1);
    step();
    check("aw_pc", pc, 32'h700);
    check("aw_brc", 32'(br_count), 32'd4);
    check("aw_brtc", 32'(br_taken_count), 32'd3);

    // Same-cycle branch and jump.
    idle();
    br(32'h80, 1'b1);
    jmp(32'h90);
    #1;
    check("bj_flush_idex", 32'(flush_idex), 32'd1);
    step();
    check("bj_pc", pc, 32'h80);

    // pc_plus4 wraps at the top of the address space.
    idle();
    jmp(32'hFFFF_FFFC);
    step();
    check("wrap_pc", pc, 32'hFFFF_FFFC);
    check("wrap_pc4", pc_plus4, 32'h0);
    idle();
    step();
    check("wrap_next", pc, 32'h0);

    // Reset in WAIT discards the pending redirect.
    idle();
    imem_ready = 0;
    jmp(32'h800);
    step();
    idle();
    #2;
    reset = 0;
    #1;
    check("rw_pc", pc, 32'h0);
    check("rw_fv", 32'(fetch_valid), 32'd0);
    check("rw_brc", 32'(br_count), 32'd0);
    @(negedge clk);
    reset = 1;
    #1;
    check("rw_fv_rel", 32'(fetch_valid), 32'd1);
    step();
    check("rw_pc_rel", pc, 32'h4);

    // Counter saturation.
    idle();
    br(32'h80, 1'b1);
    repeat (65536) step();
    check("sat_brc", 32'(br_count), 32'h0000_FFFF);
    check("sat_brtc", 32'(br_taken_count), 32'h0000_FFFF);
    step();
    check("sat_brc_hold", 32'(br_count), 32'h0000_FFFF);
    check("sat_brtc_hold", 32'(br_taken_count), 32'h0000_FFFF);

    $display("Result: errors=%0d of %0d checks", errCount, chkCount);
    $finish;
  end

endmodule

// File: doc/if_pc_redirect.md
IF_PC_REDIRECT -- requirements
Module: if_pc_redirect

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 stall  input  1  hazard-unit hold request; PC does not advance.
REQ-005 branch_valid  input  1  EX stage holds a conditional branch this cycle.
REQ-006 compareAB  input  1  EX branch comparator result; 1 = condition true.
REQ-007 branch_target  input  32  EX branch target address.
REQ-008 jump_valid  input  1  ID stage holds an unconditional jump.
REQ-009 jump_target  input  32  ID jump target address.
REQ-010 imem_ready  input  1  instruction memory accepts the fetch at pc this cycle.
REQ-011 pc  output  32  current fetch address, registered.
REQ-012 pc_plus4  output  32  pc + 4, combinational.
REQ-013 fetch_valid  output  1  the word fetched at pc this cycle is on the correct path.
REQ-014 flush_ifid  output  1  squash the IF/ID register.
REQ-015 flush_idex  output  1  squash the ID/EX register.
REQ-016 br_count  output  16  number of resolved branches, saturating.
REQ-017 br_taken_count  output  16  number of taken branches, saturating.

Function
REQ-018 Define taken = branch_valid & compareAB; redirect priority: taken branch > jump > stall > sequential.
REQ-019 Targets SHALL have bits [1:0] forced to 2'b00 before use.
REQ-020 FSM states: RUN (no pending redirect) and WAIT (imem_ready=0 seen or redirect pending); reset enters RUN.
REQ-021 RUN, imem_ready=1: pc <= taken ? branch_target : jump_valid ? jump_target : stall ? pc : pc_plus4; state stays RUN.
REQ-022 RUN, imem_ready=0: pc held; any taken/jump target latched into pend_target, pend_is_branch and pend_valid are set, and the state moves to WAIT.
REQ-023 WAIT, imem_ready=0: pc held; a new taken branch overwrites the pending target; a new jump overwrites only when no branch is pending.
REQ-024 WAIT, imem_ready=1: pending target (or a same-cycle taken branch, which wins) loads pc, the pending flags clear, and the state moves to RUN; with no redirect, REQ-021 applies.
REQ-025 fetch_valid = reset & imem_ready & ~stall & ~taken & ~jump_valid & ~pend_valid.
REQ-026 flush_ifid = taken | jump_valid; flush_idex = taken; both are combinational and asserted in the cycle the redirect is accepted or latched.
REQ-027 Stall is ignored when a redirect occurs (redirect beats stall; the wrong-path instruction is flushed).
REQ-028 pc_plus4 wraps: pc=32'hFFFF_FFFC gives 32'h0000_0000.
REQ-029 br_count increments on each cycle branch_valid=1 and stall=0; br_taken_count increments additionally when taken; both hold at 16'hFFFF.

Reset
REQ-030 While reset=0: pc=RESET_PC, state=RUN, pend_valid=0, pend_is_branch=0, pend_target=0, counters=0, fetch_valid=0; flush outputs follow REQ-026 from their inputs.
REQ-031 Reset asserted mid-WAIT discards the pending redirect; the first rising edge after release with imem_ready=1 and no redirect gives pc=RESET_PC+4.

Verification
REQ-032 Sequential run: imem_ready=1, no events, 4 cycles from reset -> pc 0,4,8,C; fetch_valid=1.
REQ-033 Taken branch plus stall: pc=0x20, stall=1, branch_valid=1, compareAB=1, target 0x100 -> flush_ifid=flush_idex=1, fetch_valid=0; next pc=0x100; br_count=br_taken_count=0 (stall=1 in that cycle, so no increment per REQ-029).
REQ-034 Not-taken branch: branch_valid=1, compareAB=0, stall=0 at pc=0x40 -> next pc=0x44; no flush; br_count +1 and br_taken_count unchanged.
REQ-035 Memory wait: imem_ready=0 with jump 0x200, next cycle branch 0x300, then imem_ready=1 -> pc held through the wait, then pc=0x300; fetch_valid=0 in the apply cycle.
REQ-036 Same-cycle branch and jump: target 0x80 vs 0x90 -> pc=0x80, flush_idex=1; counter saturation test: 65536 taken branches -> both counters 16'hFFFF.
